seven_segment_scan: RTL
=======================

# seven_segment_scan

Multiplexed, parametrised seven-segment display driver: holds a frame of `DIGITS` 4-bit codes with per-digit decimal point and blank flags, and time-multiplexes them onto one shared active-low segment bus with one-hot active-low digit enables. It sits between the application logic and the board's common-anode display pins. It adds refresh scanning, inter-digit anti-ghost gaps and tear-free frame loading.

## Interface
Parameters:
- `DIGITS`, default 4: number of digits scanned, legal range 1..8.
- `DIG_CYC`, default 50000: clock cycles each digit is lit, must be ≥1.
- `GAP_CYC`, default 16: clock cycles with all digits off before each digit, must be ≥1.

Ports:
- `clk` in 1: the single clock; all state is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: single-cycle strobe that captures the frame inputs.
- `codes` in 4*DIGITS: digit k code is `codes[4k+3:4k]`; digit 0 is the rightmost.
- `dp` in DIGITS: decimal point per digit, 1 = lit.
- `blank` in DIGITS: 1 = digit dark.
- `an` out DIGITS: digit enables, active-low, at most one bit low.
- `Display_data` out 8: `{dp,g,f,e,d,c,b,a}`, active-low.
- `frame_done` out 1: one-cycle pulse at the end of every full scan.

## Operation
- **Pending register.** `load` copies `codes`, `dp` and `blank` into the pending register in the same cycle. The last load before a frame boundary wins.
- **Display register.**
  - Copied from the pending register only at a frame boundary, so a displayed frame never mixes old and new data.
  - If `load` coincides with a boundary, the newly loaded values go straight into the display register.
- **States.** Two states plus a digit index `idx` (0..DIGITS-1) and a cycle counter.
  - GAP: `an` is all 1 and `Display_data` is 8'hFF for `GAP_CYC` cycles, then the block moves to SHOW.
  - SHOW: `an[idx]` is 0 and `Display_data` is the decode of digit `idx` for `DIG_CYC` cycles. The block then moves to GAP and increments `idx`.
  - Frame boundary: the end of SHOW with `idx` = DIGITS-1. `idx` wraps to 0, `frame_done` pulses, and the display register is updated.
- **Segment decode** (bits [6:0] gfedcba, active-low): 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000. Codes 10–15 are covered under Configuration.
- **Bit 7.** Driven as ~dp.
- **Blanked digits.** `Display_data` = 8'hFF; the digit's `an` bit still goes low for its slot, so timing is unchanged.

## Timing
- **Reset values.**
  - `an` is all 1, `Display_data` = 8'hFF, `frame_done` = 0.
  - State is GAP with `idx` = 0 and the counter at 0.
  - Display and pending registers: codes 0, `dp` 0, `blank` all 1.
  - Reset asserted mid-frame forces these values immediately, without waiting for a clock edge.
- **First lit digit.** After `rst_n` rises, digit 0 is driven on the cycle after `GAP_CYC` clock edges.
- **Registered outputs.** `an` and `Display_data` are registered and change on the same edge as the state transition. Each digit is low for exactly `DIG_CYC` cycles; each gap lasts exactly `GAP_CYC` cycles.
- **Frame period.** DIGITS*(GAP_CYC+DIG_CYC) cycles.
- **`frame_done`.** High for the one cycle that follows the last SHOW cycle of digit DIGITS-1, which is also the first GAP cycle of the new frame.
- **Load latency.** New data appears at the first SHOW of digit 0 after the next frame boundary; worst case is one frame period plus `GAP_CYC`.
- **Degenerate case.** `DIGITS`=1 behaves the same way, with every SHOW→GAP transition being a frame boundary.

## Configuration
- `SEVSEG_HEX_EN` defined: codes 10–15 decode to A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110 (gfedcba).
- Not defined: codes 10–15 give segment bits all 1. Bit 7 still follows `dp`.

## Test plan
Bench parameters: `DIGITS`=4, `DIG_CYC`=4, `GAP_CYC`=1.
- **Reset.** Hold `rst_n`=0 → `an`=4'hF, `Display_data`=8'hFF, `frame_done`=0. Release → first edge where `an`=4'hE comes after 1 GAP cycle, and shows 8'hFF because `blank` resets to all 1.
- **Basic scan.** Load codes=16'h4321, dp=0, blank=0 → after a boundary, sequence per frame: `an` E/D/B/7 with `Display_data` F9/A4/B0/99, each 4 cycles. Every digit is preceded by 1 cycle of `an`=F; `frame_done` repeats every 20 cycles.
- **Tear-free load.**
  - Load 16'h8888 mid-frame → the remaining digits of the current frame still show the old values, and the next frame shows 80 on all digits.
  - Load on the boundary cycle → the new data is used in the immediately following frame.
- **Flags.** dp=4'b0010, blank=4'b1000 with codes 16'h0000 → digit1 shows 40, digit3 shows FF while `an`=7, the others show C0.
- **Hex codes.** Codes 16'hFEDA:
  - With `SEVSEG_HEX_EN` → 88, A1, 86, 8E.
  - Without it → FF on all four digits.
- **Async reset mid-SHOW.** Pulse `rst_n` low between clock edges → `an` goes to F at once, and the restart matches the reset scenario with the loaded data cleared.

Source files
------------

// File: rtl/seven_segment_scan.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scan
// Purpose  : Multiplexed seven-segment driver for a common-anode display.
//            Holds a frame of DIGITS 4-bit codes with per-digit decimal point
//            and blank flags. Scans them one digit at a time onto a shared
//            active-low segment bus. Each digit is preceded by an all-off gap
//            to prevent ghosting. Frame loads are double-buffered, so they
//            never tear.
// Ports    : clk          - clock, all state on the rising edge
//            rst_n        - asynchronous active-low reset
//            load         - one-cycle strobe capturing codes/dp/blank
//            codes        - digit k code in codes[4k+3:4k], digit 0 rightmost
//            dp           - per-digit decimal point, 1 = lit
//            blank        - per-digit blank, 1 = dark
//            an           - active-low one-hot digit enables
//            Display_data - {dp,g,f,e,d,c,b,a}, active-low
//            frame_done   - one-cycle pulse at each frame boundary
// Options  : SEVSEG_HEX_EN - when defined, codes 10..15 show A,b,C,d,E,F.
//            When it is undefined, those codes leave every segment dark.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scan #(
    parameter int DIGITS  = 4,
    parameter int DIG_CYC = 50000,
    parameter int GAP_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   codes,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            Display_data,
    output logic                  frame_done
);

    localparam int CNT_MAX = (DIG_CYC > GAP_CYC) ? DIG_CYC : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] C_DIG_LAST = CNT_W'(DIG_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [0:0] {
        S_GAP  = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    // Segment decode, gfedcba, active-low
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
`ifdef SEVSEG_HEX_EN
            4'd10:   seg = 7'b0001000;
            4'd11:   seg = 7'b0000011;
            4'd12:   seg = 7'b1000110;
            4'd13:   seg = 7'b0100001;
            4'd14:   seg = 7'b0000110;
            4'd15:   seg = 7'b0001110;
`endif
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [7:0]           seg_q, seg_d;
    logic                 fd_q, fd_d;

    logic [4*DIGITS-1:0]  pend_codes_q, pend_codes_d;
    logic [DIGITS-1:0]    pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]    pend_blank_q, pend_blank_d;
    logic [4*DIGITS-1:0]  disp_codes_q, disp_codes_d;
    logic [DIGITS-1:0]    disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]    disp_blank_q, disp_blank_d;

    logic [3:0]           w_cur_code;
    logic                 w_cur_dp;
    logic                 w_cur_blank;
    logic [DIGITS-1:0]    w_an_sel;
    logic [7:0]           w_cur_seg;

    // Select the current digit from the display register and build its
    // active-low enable pattern
    always_comb begin
        w_cur_code  = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b1;
        w_an_sel    = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                w_cur_code  = disp_codes_q[4*k +: 4];
                w_cur_dp    = disp_dp_q[k];
                w_cur_blank = disp_blank_q[k];
                w_an_sel[k] = 1'b0;
            end
        end
        w_cur_seg = w_cur_blank ? 8'hFF : {~w_cur_dp, seg_decode(w_cur_code)};
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q + CNT_W'(1);
        an_d         = an_q;
        seg_d        = seg_q;
        fd_d         = 1'b0;
        // A load always lands in the pending register. The boundary copy
        // below reads pend_*_d, so a load on the boundary cycle goes
        // straight through to the display register.
        pend_codes_d = load ? codes : pend_codes_q;
        pend_dp_d    = load ? dp    : pend_dp_q;
        pend_blank_d = load ? blank : pend_blank_q;
        disp_codes_d = disp_codes_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;

        case (state_q)
            S_GAP: begin
                if (cnt_q == C_GAP_LAST) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                    an_d    = w_an_sel;
                    seg_d   = w_cur_seg;
                end
            end
            S_SHOW: begin
                if (cnt_q == C_DIG_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    an_d    = '1;
                    seg_d   = 8'hFF;
                    if (idx_q == C_IDX_LAST) begin
                        // Frame boundary: swap in the pending frame
                        idx_d        = '0;
                        fd_d         = 1'b1;
                        disp_codes_d = pend_codes_d;
                        disp_dp_d    = pend_dp_d;
                        disp_blank_d = pend_blank_d;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_GAP;
                cnt_d   = '0;
                an_d    = '1;
                seg_d   = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_GAP;
            idx_q        <= '0;
            cnt_q        <= '0;
            an_q         <= '1;
            seg_q        <= 8'hFF;
            fd_q         <= 1'b0;
            pend_codes_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            disp_codes_q <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            fd_q         <= fd_d;
            pend_codes_q <= pend_codes_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            disp_codes_q <= disp_codes_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
        end
    end

    assign an           = an_q;
    assign Display_data = seg_q;
    assign frame_done   = fd_q;

endmodule
`default_nettype wire
